// File: rtl/binary_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : binary_add_pipe
// Brief    : Parametrised pipelined ripple-carry adder/subtractor. The carry
//            chain is cut into WIDTH/SEG registered segments. Operand bits not
//            yet consumed ride along with each operation, and finished sum
//            segments are carried forward, so every segment of an operation
//            leaves the last stage together. Reports carry-out and signed
//            overflow.
// Revision : 1.0 - initial release
// ============================================================================
module binary_add_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] S,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    // Boundary views: index k feeds stage k, index STAGES is the registered
    // output of the last stage. w_acc holds finished sum segments below the
    // current segment and still-unconsumed bits of A above it. w_bs holds the
    // effective B operand shifted so its next segment sits in the low bits.
    logic [WIDTH-1:0] w_acc [STAGES+1];
    logic [WIDTH-1:0] w_bs  [STAGES];
    logic             w_c   [STAGES+1];
    logic             w_v   [STAGES+1];
    logic [1:0]       w_msb [STAGES+1];   // {A msb, Be msb} for overflow

    logic [WIDTH-1:0] w_be;

    assign w_be     = sub ? ~B : B;
    assign w_acc[0] = A;
    assign w_bs[0]  = w_be;
    assign w_c[0]   = sub | cin;          // subtract forces carry-in of 1
    assign w_v[0]   = in_valid;
    assign w_msb[0] = {A[WIDTH-1], w_be[WIDTH-1]};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SEG:0]     w_seg;
        logic [WIDTH-1:0] acc_d;
        logic [WIDTH-1:0] acc_q;
        logic             c_q;
        logic             v_q;
        logic [1:0]       msb_q;

        assign w_seg = {1'b0, w_acc[k][k*SEG +: SEG]}
                     + {1'b0, w_bs[k][SEG-1:0]}
                     + {{SEG{1'b0}}, w_c[k]};

        // Splice this stage's segment sum over the A bits it consumed
        always_comb begin
            acc_d                = w_acc[k];
            acc_d[k*SEG +: SEG]  = w_seg[SEG-1:0];
        end

        // Stage register: data loads on every enabled cycle, valid included
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q <= '0;
                c_q   <= 1'b0;
                v_q   <= 1'b0;
                msb_q <= 2'b00;
            end else if (en) begin
                acc_q <= acc_d;
                c_q   <= w_seg[SEG];
                v_q   <= w_v[k];
                msb_q <= w_msb[k];
            end
        end

        assign w_acc[k+1] = acc_q;
        assign w_c[k+1]   = c_q;
        assign w_v[k+1]   = v_q;
        assign w_msb[k+1] = msb_q;

        if (k < STAGES - 1) begin : g_skew
            logic [WIDTH-1:0] bs_q;

            // Skew register: remaining B segments follow their operation
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    bs_q <= '0;
                end else if (en) begin
                    bs_q <= w_bs[k] >> SEG;
                end
            end

            assign w_bs[k+1] = bs_q;
        end
    end

    logic             out_valid_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             ovf_q;
    logic             ovf_d;

    // Same-sign operands producing a result of the other sign overflowed
    assign ovf_d = (w_msb[STAGES][1] == w_msb[STAGES][0])
                && (w_acc[STAGES][WIDTH-1] != w_msb[STAGES][1]);

    // Output register: result loads only for a valid op, valid holds on stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else if (en) begin
            out_valid_q <= w_v[STAGES];
            if (w_v[STAGES]) begin
                s_q    <= w_acc[STAGES];
                cout_q <= w_c[STAGES];
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign S         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_binary_add_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_binary_add_pipe
// Brief    : Self-checking bench for binary_add_pipe (32/8 and 14/14 configs).
//            Expected results are queued when an op is accepted and compared,
//            including their arrival cycle, when the DUT presents them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_binary_add_pipe;

    localparam int W  = 32;
    localparam int SG = 8;
    localparam int ST = W / SG;
    localparam int W1 = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, iv, sb, ci;
    logic [W-1:0]  a, b;
    logic          ov, co, of;
    logic [W-1:0]  s;

    logic          iv1, sb1, ci1;
    logic [W1-1:0] a1, b1;
    logic          ov1, co1, of1;
    logic [W1-1:0] s1;

    binary_add_pipe #(.WIDTH(W), .SEG(SG)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(iv), .A(a), .B(b),
        .sub(sb), .cin(ci), .out_valid(ov), .S(s), .cout(co), .ovf(of)
    );

    binary_add_pipe #(.WIDTH(W1), .SEG(W1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(iv1), .A(a1), .B(b1),
        .sub(sb1), .cin(ci1), .out_valid(ov1), .S(s1), .cout(co1), .ovf(of1)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         of;
        int           due;
    } exp_t;

    exp_t q[$];
    exp_t q1[$];
    int   ecnt  = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic exp_t model(input logic [W-1:0] x, y, input logic m, c, input int d);
        exp_t         e;
        logic [W-1:0] ye;
        logic [W:0]   t;
        ye    = m ? ~y : y;
        t     = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, (m | c)};
        e.s   = t[W-1:0];
        e.co  = t[W];
        e.of  = (x[W-1] == ye[W-1]) && (t[W-1] != x[W-1]);
        e.due = d;
        return e;
    endfunction

    function automatic exp_t model14(input logic [W1-1:0] x, y, input logic m, c, input int d);
        exp_t          e;
        logic [W1-1:0] ye;
        logic [W1:0]   t;
        ye    = m ? ~y : y;
        t     = {1'b0, x} + {1'b0, ye} + {{W1{1'b0}}, (m | c)};
        e.s   = {{(W-W1){1'b0}}, t[W1-1:0]};
        e.co  = t[W1];
        e.of  = (x[W1-1] == ye[W1-1]) && (t[W1-1] != x[W1-1]);
        e.due = d;
        return e;
    endfunction

    // One clock of stimulus on the wide DUT; queues the expected result
    task automatic cyc(input logic e_, v_, input logic [W-1:0] x, y, input logic m, c);
        @(negedge clk);
        en = e_; iv = v_; a = x; b = y; sb = m; ci = c;
        if (e_ && v_) q.push_back(model(x, y, m, c, ecnt + 1 + ST));
        @(posedge clk);
        if (e_) ecnt++;
        #1;
    endtask

    // One clock of stimulus on the single-stage DUT
    task automatic cyc1(input logic v_, input logic [W1-1:0] x, y, input logic m, c);
        @(negedge clk);
        en = 1'b1; iv = 1'b0; iv1 = v_; a1 = x; b1 = y; sb1 = m; ci1 = c;
        if (v_) q1.push_back(model14(x, y, m, c, ecnt + 2));
        @(posedge clk);
        ecnt++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; iv = 1'b0; a = '0; b = '0; sb = 1'b0; ci = 1'b0;
        iv1 = 1'b0; a1 = '0; b1 = '0; sb1 = 1'b0; ci1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({ov, s, co, of} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got ov=%b S=%h cout=%b ovf=%b, expected all 0", ov, s, co, of);
        end
        n_cmp++;
        if ({ov1, s1, co1, of1} !== '0) begin
            n_bad++;
            $display("FAIL reset_state_single: got ov=%b S=%h cout=%b ovf=%b, expected all 0", ov1, s1, co1, of1);
        end
        @(negedge clk);
        rst = 1'b0;
        // Fill both pipelines with valid ops (not scoreboarded: reset discards them)
        for (int i = 0; i <= ST; i++) begin
            @(negedge clk);
            en = 1'b1; iv = 1'b1; a = 32'h1000_0000; b = 32'hFFFF_FFFF;
            iv1 = 1'b1; a1 = 14'h3FFF; b1 = 14'h3FFF;
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({ov, s, co, of} !== {1'b1, 32'h0FFF_FFFF, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL prefill_result: got ov=%b S=%h cout=%b ovf=%b, expected 1 0fffffff 1 0", ov, s, co, of);
        end
        n_cmp++;
        if ({ov1, s1, co1, of1} !== {1'b1, 14'h3FFE, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL prefill_single: got ov=%b S=%h cout=%b ovf=%b, expected 1 3ffe 1 0", ov1, s1, co1, of1);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ov, s, co, of, ov1, s1, co1, of1} !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got ov=%b S=%h cout=%b ovf=%b ov1=%b S1=%h, expected all 0", ov, s, co, of, ov1, s1);
        end
        @(negedge clk);
        iv = 1'b0; iv1 = 1'b0; rst = 1'b0;
        for (int i = 0; i < ST + 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (ov !== 1'b0 || ov1 !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset_leak: got ov=%b ov1=%b, expected 0 0", ov, ov1);
            end
        end
    endtask

    task automatic test_arith();
        logic [W-1:0] ta [5] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5, 32'd2};
        logic [W-1:0] tb [5] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'd7, 32'd3};
        logic         ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic         tc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        exp_t         e;
        for (int i = 0; i < 10 + ST + 3; i++) begin
            if (i < 10 && i % 2 == 0) cyc(1'b1, 1'b1, ta[i/2], tb[i/2], ts[i/2], tc[i/2]);
            else                      cyc(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
            if (ov) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL arith_spurious: got out_valid=1 S=%h, expected no result", s);
                end else begin
                    e = q.pop_front();
                    if ({s, co, of} !== {e.s, e.co, e.of} || ecnt != e.due) begin
                        n_bad++;
                        $display("FAIL arith_result: got S=%h cout=%b ovf=%b at %0d, expected S=%h cout=%b ovf=%b at %0d",
                                 s, co, of, ecnt, e.s, e.co, e.of, e.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= ecnt) begin
                e = q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL arith_missing: got out_valid=0 at %0d, expected S=%h", ecnt, e.s);
            end
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL arith_drain: got %0d results outstanding, expected 0", q.size());
        end
    endtask

    task automatic test_stall();
        // per cycle: en, in_valid, operand (op is x + x)
        logic         se [13] = '{1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1};
        logic         sv [13] = '{1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0};
        logic [W-1:0] sx [13] = '{1, 0, 2, 0, 0, 3, 4, 0, 0, 0, 0, 0, 0};
        exp_t         e;
        logic         p_ov;
        logic [W-1:0] p_s;
        int           last_out = -1;
        p_ov = ov; p_s = s;
        for (int i = 0; i < 13; i++) begin
            cyc(se[i], sv[i], sx[i], sx[i], 1'b0, 1'b0);
            if (!se[i]) begin
                n_cmp++;
                if (ov !== p_ov || s !== p_s) begin
                    n_bad++;
                    $display("FAIL stall_hold: got ov=%b S=%h, expected ov=%b S=%h", ov, s, p_ov, p_s);
                end
            end else if (ov) begin
                n_cmp++;
                last_out = i;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL stall_spurious: got out_valid=1 S=%h, expected no result", s);
                end else begin
                    e = q.pop_front();
                    if (s !== e.s || ecnt != e.due) begin
                        n_bad++;
                        $display("FAIL stall_result: got S=%h at %0d, expected S=%h at %0d", s, ecnt, e.s, e.due);
                    end
                end
            end else begin
                n_cmp++;
                if (s !== p_s) begin
                    n_bad++;
                    $display("FAIL bubble_hold: got S=%h, expected S=%h", s, p_s);
                end
                if (q.size() > 0 && q[0].due <= ecnt) begin
                    e = q.pop_front();
                    n_bad++;
                    $display("FAIL stall_missing: got out_valid=0 at %0d, expected S=%h", ecnt, e.s);
                end
            end
            p_ov = ov; p_s = s;
        end
        n_cmp++;
        if (last_out != 10 || q.size() != 0) begin
            n_bad++;
            $display("FAIL stall_span: got last output at cycle %0d with %0d pending, expected cycle 10 with 0", last_out, q.size());
        end
    endtask

    task automatic test_random();
        exp_t         e;
        logic         p_ov, p_co, p_of, e_;
        logic [W-1:0] p_s, x, y;
        p_ov = ov; p_s = s; p_co = co; p_of = of;
        for (int i = 0; i < 320; i++) begin
            e_ = (i >= 300) || ($urandom_range(0, 9) < 8);
            x  = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
            y  = ($urandom_range(0, 7) == 0) ? W'(1) : W'($urandom);
            cyc(e_, (i < 300) && ($urandom_range(0, 3) != 0), x, y, 1'($urandom), 1'($urandom));
            if (!e_) begin
                n_cmp++;
                if ({ov, s, co, of} !== {p_ov, p_s, p_co, p_of}) begin
                    n_bad++;
                    $display("FAIL random_hold: got ov=%b S=%h, expected ov=%b S=%h", ov, s, p_ov, p_s);
                end
            end else if (ov) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL random_spurious: got out_valid=1 S=%h, expected no result", s);
                end else begin
                    e = q.pop_front();
                    if ({s, co, of} !== {e.s, e.co, e.of} || ecnt != e.due) begin
                        n_bad++;
                        $display("FAIL random_result: got S=%h cout=%b ovf=%b at %0d, expected S=%h cout=%b ovf=%b at %0d",
                                 s, co, of, ecnt, e.s, e.co, e.of, e.due);
                    end
                end
            end else if (q.size() > 0 && q[0].due <= ecnt) begin
                e = q.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL random_missing: got out_valid=0 at %0d, expected S=%h", ecnt, e.s);
            end
            p_ov = ov; p_s = s; p_co = co; p_of = of;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL random_drain: got %0d results outstanding, expected 0", q.size());
        end
    endtask

    task automatic test_single();
        exp_t e;
        for (int i = 0; i < 45; i++) begin
            if (i == 0)      cyc1(1'b1, 14'h3FFF, 14'h0001, 1'b0, 1'b0);
            else if (i < 42) cyc1(1'b1, W1'($urandom), W1'($urandom), 1'($urandom), 1'($urandom));
            else             cyc1(1'b0, '0, '0, 1'b0, 1'b0);
            if (i == 1) begin
                n_cmp++;
                if ({ov1, s1, co1} !== {1'b1, 14'h0000, 1'b1}) begin
                    n_bad++;
                    $display("FAIL single_wrap: got ov=%b S=%h cout=%b, expected 1 0000 1", ov1, s1, co1);
                end
            end
            if (ov1) begin
                n_cmp++;
                if (q1.size() == 0) begin
                    n_bad++;
                    $display("FAIL single_spurious: got out_valid=1 S=%h, expected no result", s1);
                end else begin
                    e = q1.pop_front();
                    if ({{(W-W1){1'b0}}, s1, co1, of1} !== {e.s, e.co, e.of} || ecnt != e.due) begin
                        n_bad++;
                        $display("FAIL single_result: got S=%h cout=%b ovf=%b at %0d, expected S=%h cout=%b ovf=%b at %0d",
                                 s1, co1, of1, ecnt, e.s, e.co, e.of, e.due);
                    end
                end
            end else if (q1.size() > 0 && q1[0].due <= ecnt) begin
                e = q1.pop_front();
                n_cmp++; n_bad++;
                $display("FAIL single_missing: got out_valid=0 at %0d, expected S=%h", ecnt, e.s);
            end
        end
        n_cmp++;
        if (q1.size() != 0) begin
            n_bad++;
            $display("FAIL single_drain: got %0d results outstanding, expected 0", q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_stall();
        test_random();
        test_single();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/binary_add_pipe.md
# binary_add_pipe

Parametrised, pipelined ripple-carry adder/subtractor. It generalises the team's fixed-width registered adder to any width and splits the carry chain into registered segments so wide operands meet timing. It accepts one operation per enabled cycle with a valid tag, supports add and subtract, and reports carry-out and signed overflow. It sits in the datapath wherever a wide registered sum is needed at full clock rate.

## Interface
- WIDTH, 32: operand/result width in bits; must be a multiple of SEG.
- SEG, 8: bits per pipeline segment; STAGES = WIDTH/SEG (SEG = WIDTH gives a single-stage adder).
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  pipeline advance; 0 freezes every register, including valids.
- in_valid  input  1  operation present on A/B/sub/cin this cycle.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- sub  input  1  0: S = A + B + cin; 1: S = A − B (cin ignored).
- cin  input  1  carry-in for add.
- out_valid  output  1  S/cout/ovf hold a new result this cycle.
- S  output  WIDTH  result.
- cout  output  1  carry out of MSB (for subtract, 1 = no borrow).
- ovf  output  1  signed overflow.

## Operation
- Effective operand Be = sub ? ~B : B; effective carry c0 = sub ? 1 : cin.
- Stage k (k = 0..STAGES−1) adds segment k of A and Be (bits k·SEG .. k·SEG+SEG−1) plus the carry registered by stage k−1 (stage 0 uses c0).
- Operand segments for stage k are delayed k cycles by skew registers; result segments from stage k are delayed STAGES−1−k cycles by deskew registers, so all segments of one operation appear together.
- sub and the operand MSBs travel with their operation to the last stage for ovf.
- ovf = (A[WIDTH−1] == Be[WIDTH−1]) && (S[WIDTH−1] != A[WIDTH−1]).
- cout = carry out of the top segment.
- A valid bit travels alongside each stage. Internal data registers load on every enabled cycle regardless of valid.
- Output registers S/cout/ovf load only when en = 1 and the last-stage valid = 1; otherwise they hold their value.
- out_valid = registered last-stage valid. It is cleared when en = 1 and no valid reaches the output. It holds when en = 0.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

## Timing
- Reset (rst = 1, asynchronous): every pipeline, skew, valid and output register goes to 0; out_valid = 0, S = 0, cout = 0, ovf = 0 while rst is high and until the first result after release.
- Latency: an operation accepted at edge n (en = 1, in_valid = 1) produces out_valid = 1 with its result after edge n + STAGES − 1 + 1, i.e. STAGES enabled cycles. STAGES = 1 gives one-cycle registered output.
- Throughput: one operation per enabled cycle; there is no backpressure beyond en.
- en = 0 cycles add exactly one cycle of latency each to every in-flight operation. Results keep order; none are lost or duplicated; out_valid is held, not pulsed again.
- Reset mid-stream discards all in-flight operations; none emerge after release.
- in_valid = 0 inserts a bubble; out_valid = 0 for the matching output cycle, and S holds its previous result.

## Test plan
- Reset: assert rst with a pipeline full of valid ops -> out_valid, S, cout, ovf = 0 immediately (before next clk edge). After release with no input, out_valid stays 0.
- Full carry ripple (WIDTH = 32, SEG = 8): A = 0xFFFFFFFF, B = 0x00000001, sub = 0, cin = 0 -> 4 cycles later S = 0x00000000, cout = 1, ovf = 0, out_valid = 1 for one cycle.
- Signed overflow: A = 0x7FFFFFFF, B = 0x00000001, cin = 0 -> S = 0x80000000, cout = 0, ovf = 1. Also A = 0x80000000, sub = 1, B = 1 -> S = 0x7FFFFFFF, ovf = 1, cout = 1.
- Subtract with borrow: A = 5, B = 7, sub = 1, cin = 1 -> S = 0xFFFFFFFE, cout = 0, ovf = 0 (cin ignored). Add with cin: A = 2, B = 3, cin = 1 -> S = 6.
- Stall/bubble stream: issue ops 1+1, bubble, 2+2, 3+3, 4+4, with en = 0 for 2 cycles after the third issue -> outputs 2, (bubble, out_valid = 0, S holds 2), 4, 6, 8 in order. Total span is extended by exactly 2 cycles. out_valid is held through the stall.
- Single-stage config (SEG = WIDTH = 14): A = 0x3FFF, B = 1 -> one cycle later S = 0x0000, cout = 1. Random back-to-back traffic matches a reference model A ± B on every out_valid.
